// File: rtl/bpu_ras_pkg.sv
// rtl/bpu_ras_pkg.sv - shared return-address-stack types and target-type encodings
package bpu_ras_pkg;

    localparam int RAS_DEPTH  = 8;
    localparam int RAS_ADDR_W = 32;
    localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W  = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] BPU_TARGET_NPC    = 2'd0;
    localparam logic [1:0] BPU_TARGET_CALL   = 2'd1;
    localparam logic [1:0] BPU_TARGET_RETURN = 2'd2;
    localparam logic [1:0] BPU_TARGET_OTHER  = 2'd3;

    // Snapshot carried down the pipe with every prediction.
    typedef struct packed {
        logic [RAS_PTR_W-1:0] ptr;
        logic [RAS_CNT_W-1:0] cnt;
    } ras_ckpt_t;

endpackage

// File: rtl/bpu_ras_lutram.sv
// rtl/bpu_ras_lutram.sv - single-write, async-read LUT RAM holding RAS entries
module bpu_ras_lutram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bpu_ras.sv
// rtl/bpu_ras.sv - checkpointed return address stack with committed-state recovery
module bpu_ras
    import bpu_ras_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              top_valid_o,
    output logic [PTR_W-1:0]  ckpt_ptr_o,
    output logic [CNT_W-1:0]  ckpt_cnt_o,
    input  logic              miss_i,
    input  logic [1:0]        miss_type_i,
    input  logic [PTR_W-1:0]  miss_ptr_i,
    input  logic [CNT_W-1:0]  miss_cnt_i,
    input  logic [ADDR_W-1:0] miss_pc_i,
    input  logic              commit_push_i,
    input  logic              commit_pop_i,
    input  logic              flush_i
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  ptr_q, ptr_d, cptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, ccnt_q;
    logic [PTR_W-1:0]  ptr_dec;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_data;

    assign ptr_dec = ptr_q - PTR_ONE;

    // Priority: flush > correction > stall > push/pop; correction owns the write port.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = push_addr_i;
        if (flush_i) begin
            ptr_d = cptr_q;
            cnt_d = ccnt_q;
        end else if (miss_i) begin
            case (miss_type_i)
                BPU_TARGET_CALL: begin
                    wr_en   = 1'b1;
                    wr_addr = miss_ptr_i;
                    wr_data = miss_pc_i + ADDR_W'(4);
                    ptr_d   = miss_ptr_i + PTR_ONE;
                    cnt_d   = (miss_cnt_i >= CNT_MAX) ? CNT_MAX : miss_cnt_i + CNT_ONE;
                end
                BPU_TARGET_RETURN: begin
                    ptr_d = miss_ptr_i - PTR_ONE;
                    cnt_d = (miss_cnt_i == '0) ? '0 : miss_cnt_i - CNT_ONE;
                end
                default: begin
                    ptr_d = miss_ptr_i;
                    cnt_d = miss_cnt_i;
                end
            endcase
        end else if (!stall_i) begin
            if (push_i && pop_i) begin
                wr_en   = 1'b1;
                wr_addr = ptr_dec;
            end else if (push_i) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + PTR_ONE;
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            end else if (pop_i) begin
                // Pointer moves even when empty to keep slot alignment.
                ptr_d = ptr_dec;
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            cptr_q <= '0;
            ccnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (commit_push_i && !commit_pop_i) begin
                cptr_q <= cptr_q + PTR_ONE;
                ccnt_q <= (ccnt_q == CNT_MAX) ? CNT_MAX : ccnt_q + CNT_ONE;
            end else if (commit_pop_i && !commit_push_i) begin
                cptr_q <= cptr_q - PTR_ONE;
                ccnt_q <= (ccnt_q == '0) ? '0 : ccnt_q - CNT_ONE;
            end
        end
    end

    bpu_ras_lutram #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W),
        .AW    (PTR_W)
    ) u_stack (
        .clk   (clk),
        .we    (wr_en && !rst),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ptr_dec),
        .rdata (rd_data)
    );

    assign top_o       = (cnt_q == '0) ? '0 : rd_data;
    assign top_valid_o = (cnt_q != '0);
    assign ckpt_ptr_o  = ptr_q;
    assign ckpt_cnt_o  = cnt_q;

endmodule

// File: tb/tb_bpu_ras.sv
// tb/tb_bpu_ras.sv - randomized self-checking bench for bpu_ras against a behavioural model
module tb_bpu_ras;
    import bpu_ras_pkg::*;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, push_i, pop_i;
    logic [31:0] push_addr_i;
    logic [31:0] top_o;
    logic        top_valid_o;
    logic [2:0]  ckpt_ptr_o;
    logic [3:0]  ckpt_cnt_o;
    logic        miss_i;
    logic [1:0]  miss_type_i;
    logic [2:0]  miss_ptr_i;
    logic [3:0]  miss_cnt_i;
    logic [31:0] miss_pc_i;
    logic        commit_push_i, commit_pop_i, flush_i;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_stack [D];
    int m_ptr, m_cnt, m_cptr, m_ccnt;

    always #5 clk = ~clk;

    bpu_ras #(.DEPTH(D), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .push_i(push_i), .pop_i(pop_i),
        .push_addr_i(push_addr_i), .top_o(top_o), .top_valid_o(top_valid_o),
        .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o), .miss_i(miss_i),
        .miss_type_i(miss_type_i), .miss_ptr_i(miss_ptr_i), .miss_cnt_i(miss_cnt_i),
        .miss_pc_i(miss_pc_i), .commit_push_i(commit_push_i), .commit_pop_i(commit_pop_i),
        .flush_i(flush_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % D) + D) % D;
    endfunction

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > D) ? D : v);
    endfunction

    // Model of one clock edge, using the inputs held through that edge.
    function automatic void model_update();
        int old_cptr, old_ccnt;
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_cptr = 0; m_ccnt = 0;
            return;
        end
        old_cptr = m_cptr;
        old_ccnt = m_ccnt;
        if (commit_push_i && !commit_pop_i) begin
            m_cptr = wrap(m_cptr + 1); m_ccnt = clampc(m_ccnt + 1);
        end else if (commit_pop_i && !commit_push_i) begin
            m_cptr = wrap(m_cptr - 1); m_ccnt = clampc(m_ccnt - 1);
        end
        if (flush_i) begin
            m_ptr = old_cptr; m_cnt = old_ccnt;
        end else if (miss_i) begin
            if (miss_type_i == BPU_TARGET_CALL) begin
                m_stack[miss_ptr_i] = miss_pc_i + 32'd4;
                m_ptr = wrap(int'(miss_ptr_i) + 1);
                m_cnt = clampc(int'(miss_cnt_i) + 1);
            end else if (miss_type_i == BPU_TARGET_RETURN) begin
                m_ptr = wrap(int'(miss_ptr_i) - 1);
                m_cnt = clampc(int'(miss_cnt_i) - 1);
            end else begin
                m_ptr = int'(miss_ptr_i);
                m_cnt = int'(miss_cnt_i);
            end
        end else if (!stall_i) begin
            if (push_i && pop_i) begin
                m_stack[wrap(m_ptr - 1)] = push_addr_i;
            end else if (push_i) begin
                m_stack[m_ptr] = push_addr_i;
                m_ptr = wrap(m_ptr + 1); m_cnt = clampc(m_cnt + 1);
            end else if (pop_i) begin
                m_ptr = wrap(m_ptr - 1); m_cnt = clampc(m_cnt - 1);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_top", top_o, (m_cnt == 0) ? 32'h0 : m_stack[wrap(m_ptr - 1)]);
            check("model_valid", 32'(top_valid_o), 32'(m_cnt != 0));
            check("model_ptr", 32'(ckpt_ptr_o), 32'(m_ptr));
            check("model_cnt", 32'(ckpt_cnt_o), 32'(m_cnt));
        end
    end

    task automatic clear_inputs();
        rst = 0; stall_i = 0; push_i = 0; pop_i = 0; push_addr_i = 0;
        miss_i = 0; miss_type_i = 0; miss_ptr_i = 0; miss_cnt_i = 0; miss_pc_i = 0;
        commit_push_i = 0; commit_pop_i = 0; flush_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs(); rst = 1; step(); step(); rst = 0;
    endtask

    task automatic do_push(input logic [31:0] a);
        clear_inputs(); push_i = 1; push_addr_i = a; step();
    endtask

    task automatic do_pop();
        clear_inputs(); pop_i = 1; step();
    endtask

    initial begin
        clear_inputs();
        do_reset();
        cmp_en = 1'b1;
        check("reset_top", top_o, 32'h0);
        check("reset_valid", 32'(top_valid_o), 32'h0);
        check("reset_ptr", 32'(ckpt_ptr_o), 32'h0);
        check("reset_cnt", 32'(ckpt_cnt_o), 32'h0);

        do_push(32'h1000); check("push1_top", top_o, 32'h1000);
        do_push(32'h2000); check("push2_top", top_o, 32'h2000);
        do_push(32'h3000); check("push3_top", top_o, 32'h3000);
        check("push3_cnt", 32'(ckpt_cnt_o), 32'd3);
        check("push3_ptr", 32'(ckpt_ptr_o), 32'd3);
        do_pop(); do_pop();
        check("pop2_top", top_o, 32'h1000);
        check("pop2_cnt", 32'(ckpt_cnt_o), 32'd1);

        do_reset();
        for (int k = 1; k <= 9; k++) do_push(32'h100 * k);
        check("full_cnt", 32'(ckpt_cnt_o), 32'd8);
        check("full_top", top_o, 32'h900);
        for (int i = 1; i <= 7; i++) begin
            do_pop();
            check("wrap_pop_top", top_o, 32'h100 * (9 - i));
        end
        check("wrap_pop7_valid", 32'(top_valid_o), 32'd1);
        do_pop();
        check("wrap_pop8_valid", 32'(top_valid_o), 32'd0);
        check("wrap_pop8_top", top_o, 32'h0);

        do_reset();
        do_pop();
        check("empty_cnt", 32'(ckpt_cnt_o), 32'd0);
        check("empty_valid", 32'(top_valid_o), 32'd0);
        check("empty_top", top_o, 32'h0);
        check("empty_ptr", 32'(ckpt_ptr_o), 32'd7);

        do_reset();
        do_push(32'hA0); do_push(32'hB0);
        clear_inputs();
        miss_i = 1; miss_type_i = BPU_TARGET_CALL; miss_ptr_i = 3'd1; miss_cnt_i = 4'd1;
        miss_pc_i = 32'h4000; push_i = 1; push_addr_i = 32'hFF;
        step();
        check("miss_ptr", 32'(ckpt_ptr_o), 32'd2);
        check("miss_cnt", 32'(ckpt_cnt_o), 32'd2);
        check("miss_top", top_o, 32'h4004);

        do_reset();
        do_push(32'hC0);
        clear_inputs(); commit_push_i = 1; step();
        do_push(32'hD0); do_push(32'hE0);
        check("pre_flush_top", top_o, 32'hE0);
        clear_inputs(); flush_i = 1; step();
        check("flush_ptr", 32'(ckpt_ptr_o), 32'd1);
        check("flush_cnt", 32'(ckpt_cnt_o), 32'd1);
        check("flush_top", top_o, 32'hC0);

        clear_inputs(); stall_i = 1; push_i = 1; push_addr_i = 32'h77; step();
        check("stall_ptr", 32'(ckpt_ptr_o), 32'd1);
        check("stall_cnt", 32'(ckpt_cnt_o), 32'd1);
        check("stall_top", top_o, 32'hC0);
        do_push(32'h50);
        clear_inputs(); push_i = 1; pop_i = 1; push_addr_i = 32'h60; step();
        check("pushpop_top", top_o, 32'h60);
        check("pushpop_cnt", 32'(ckpt_cnt_o), 32'd2);

        // Fill every slot so random corrections never read unwritten storage.
        for (int k = 0; k < D; k++) do_push(32'h9000 + k);

        for (int n = 0; n < 4000; n++) begin
            clear_inputs();
            rst         = ($urandom_range(0, 499) == 0);
            flush_i     = ($urandom_range(0, 31) == 0);
            miss_i      = ($urandom_range(0, 15) == 0);
            miss_type_i = 2'($urandom_range(0, 3));
            miss_ptr_i  = 3'($urandom_range(0, 7));
            miss_cnt_i  = 4'($urandom_range(0, 8));
            miss_pc_i   = $urandom;
            stall_i     = ($urandom_range(0, 7) == 0);
            push_i      = $urandom_range(0, 1) == 1;
            pop_i       = $urandom_range(0, 1) == 1;
            push_addr_i = $urandom;
            if (!flush_i) begin
                commit_push_i = ($urandom_range(0, 3) == 0);
                commit_pop_i  = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        clear_inputs();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
